// File: rtl/mdc_delay_commutator.sv
// Radix-2 MDC delay-commutator: reorders the two lane-packed complex streams of one
// butterfly stage so the next stage sees operand pairs (x[i], x[i+DEPTH]).
module mdc_delay_commutator #(
   parameter int NB    = 9,
   parameter int LANES = 4,
   parameter int DEPTH = 4
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                START,
   input  logic                IN_VALID,
   input  logic [NB*LANES-1:0] IAR,
   input  logic [NB*LANES-1:0] IAI,
   input  logic [NB*LANES-1:0] IBR,
   input  logic [NB*LANES-1:0] IBI,
   output logic                OUT_VALID,
   output logic                OUT_START,
   output logic [NB*LANES-1:0] OAR,
   output logic [NB*LANES-1:0] OAI,
   output logic [NB*LANES-1:0] OBR,
   output logic [NB*LANES-1:0] OBI
);

   localparam int W    = NB * LANES;
   localparam int SELB = $clog2(DEPTH);
   localparam int KW   = SELB + 1;

   typedef logic [2*W-1:0] word_t;

   // Handshake: IN_VALID qualifies the input pair and there is no ready, so every
   // high cycle is consumed; OUT_VALID marks a reordered pair, likewise unthrottled.
   logic          accept;
   logic [KW-1:0] k;
   logic [KW-1:0] k_cur;
   logic          fill;
   logic          fill_cur;
   logic          sel;

   word_t da [DEPTH];
   word_t db [DEPTH];
   word_t a_in;
   word_t b_in;
   word_t out0;
   word_t lower;

   assign accept = IN_VALID;
   assign a_in   = {IAR, IAI};
   assign b_in   = {IBR, IBI};

   // START re-bases the current cycle, so it is seen as k=0 with an empty pipe.
   assign k_cur    = START ? '0 : k;
   assign fill_cur = START ? 1'b0 : fill;
   assign sel      = k_cur[SELB];

   always_comb begin
      out0  = da[DEPTH-1];
      lower = b_in;
      if (sel) begin
         out0  = b_in;
         lower = da[DEPTH-1];
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         k    <= '0;
         fill <= 1'b0;
      end else if (accept) begin
         k    <= k_cur + KW'(1);
         fill <= fill_cur | (k_cur == KW'(2*DEPTH-1));
      end else begin
         k    <= k_cur;
         fill <= fill_cur;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            da[i] <= '0;
            db[i] <= '0;
         end
      end else if (accept) begin
         da[0] <= a_in;
         db[0] <= lower;
         for (int i = 1; i < DEPTH; i++) begin
            da[i] <= da[i-1];
            db[i] <= db[i-1];
         end
      end
   end

   // Data registers hold through stalls; only the qualifiers drop.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         OUT_VALID <= 1'b0;
         OUT_START <= 1'b0;
         OAR       <= '0;
         OAI       <= '0;
         OBR       <= '0;
         OBI       <= '0;
      end else if (accept) begin
         OUT_VALID  <= fill_cur;
         OUT_START  <= fill_cur && (k_cur == '0);
         {OAR, OAI} <= out0;
         {OBR, OBI} <= db[DEPTH-1];
      end else begin
         OUT_VALID <= 1'b0;
         OUT_START <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mdc_delay_commutator.sv
// Bench for mdc_delay_commutator: DEPTH=4 and DEPTH=1 instances share stimulus and are
// checked against a pair-index reference model built from accepted-sample history.
module tb_mdc_delay_commutator;

   localparam int NB    = 9;
   localparam int LANES = 4;
   localparam int W     = NB * LANES;

   logic         clk;
   logic         rst;
   logic         start;
   logic         in_valid;
   logic [W-1:0] iar, iai, ibr, ibi;

   logic         out_valid_4, out_start_4;
   logic [W-1:0] oar_4, oai_4, obr_4, obi_4;
   logic         out_valid_1, out_start_1;
   logic [W-1:0] oar_1, oai_1, obr_1, obi_1;

   int n_checks = 0;
   int n_fail   = 0;
   logic chk_en = 1'b0;

   mdc_delay_commutator #(.NB(NB), .LANES(LANES), .DEPTH(4)) dut_d4 (
      .CLK(clk), .RST(rst), .START(start), .IN_VALID(in_valid),
      .IAR(iar), .IAI(iai), .IBR(ibr), .IBI(ibi),
      .OUT_VALID(out_valid_4), .OUT_START(out_start_4),
      .OAR(oar_4), .OAI(oai_4), .OBR(obr_4), .OBI(obi_4)
   );

   mdc_delay_commutator #(.NB(NB), .LANES(LANES), .DEPTH(1)) dut_d1 (
      .CLK(clk), .RST(rst), .START(start), .IN_VALID(in_valid),
      .IAR(iar), .IAI(iai), .IBR(ibr), .IBI(ibi),
      .OUT_VALID(out_valid_1), .OUT_START(out_start_1),
      .OAR(oar_1), .OAI(oai_1), .OBR(obr_1), .OBI(obi_1)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- checker ----------------
   task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Pairs are defined by accepted-sample index n since the last START/reset:
   // first half of a 2D group pairs A[n-D] with A[n-2D], second half B[n] with B[n-D].
   logic [2*W-1:0] a_hist[$];
   logic [2*W-1:0] b_hist[$];

   logic           e4_valid, e4_start, e4_known;
   logic [2*W-1:0] e4_oa, e4_ob;
   logic           e1_valid, e1_start, e1_known;
   logic [2*W-1:0] e1_oa, e1_ob;

   function automatic void ref_out(input int d, input int n, output logic v, output logic s,
                                   output logic [2*W-1:0] oa, output logic [2*W-1:0] ob);
      int k;
      k  = n % (2 * d);
      v  = (n >= 2 * d);
      s  = v && (k == 0);
      oa = '0;
      ob = '0;
      if (v) begin
         if (k < d) begin
            oa = a_hist[n-d];
            ob = a_hist[n-2*d];
         end else begin
            oa = b_hist[n];
            ob = b_hist[n-d];
         end
      end
   endfunction

   always @(posedge clk or posedge rst) begin : ref_model
      logic           v, s;
      logic [2*W-1:0] oa, ob;
      int             n;
      if (rst) begin
         a_hist.delete();
         b_hist.delete();
         e4_valid <= 1'b0; e4_start <= 1'b0; e4_known <= 1'b1; e4_oa <= '0; e4_ob <= '0;
         e1_valid <= 1'b0; e1_start <= 1'b0; e1_known <= 1'b1; e1_oa <= '0; e1_ob <= '0;
      end else begin
         if (start) begin
            a_hist.delete();
            b_hist.delete();
         end
         if (in_valid) begin
            a_hist.push_back({iar, iai});
            b_hist.push_back({ibr, ibi});
            n = a_hist.size() - 1;
            ref_out(4, n, v, s, oa, ob);
            e4_valid <= v; e4_start <= s; e4_known <= v;
            if (v) begin e4_oa <= oa; e4_ob <= ob; end
            ref_out(1, n, v, s, oa, ob);
            e1_valid <= v; e1_start <= s; e1_known <= v;
            if (v) begin e1_oa <= oa; e1_ob <= ob; end
         end else begin
            e4_valid <= 1'b0; e4_start <= 1'b0;
            e1_valid <= 1'b0; e1_start <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check_eq("valid_d4", 72'(out_valid_4), 72'(e4_valid));
         check_eq("start_d4", 72'(out_start_4), 72'(e4_start));
         if (e4_known) begin
            check_eq("oa_d4", {oar_4, oai_4}, e4_oa);
            check_eq("ob_d4", {obr_4, obi_4}, e4_ob);
         end
         check_eq("valid_d1", 72'(out_valid_1), 72'(e1_valid));
         check_eq("start_d1", 72'(out_start_1), 72'(e1_start));
         if (e1_known) begin
            check_eq("oa_d1", {oar_1, oai_1}, e1_oa);
            check_eq("ob_d1", {obr_1, obi_1}, e1_ob);
         end
      end
   end

   // ---------------- drivers ----------------
   function automatic logic [W-1:0] splat(input int v);
      logic [W-1:0] r;
      for (int l = 0; l < LANES; l++) r[NB*l +: NB] = NB'(v);
      return r;
   endfunction

   function automatic logic [W-1:0] per_lane(input int idx, input bit neg);
      logic [W-1:0] r;
      for (int l = 0; l < LANES; l++)
         r[NB*l +: NB] = neg ? NB'(-(100 * l + idx)) : NB'(100 * l + idx);
      return r;
   endfunction

   function automatic logic [W-1:0] rnd_word();
      return W'({$urandom(), $urandom()});
   endfunction

   task automatic drive(input logic st, input logic v, input logic [W-1:0] ar,
                        input logic [W-1:0] ai, input logic [W-1:0] br, input logic [W-1:0] bi);
      @(negedge clk);
      start    = st;
      in_valid = v;
      iar      = ar;
      iai      = ai;
      ibr      = br;
      ibi      = bi;
   endtask

   task automatic idle(input int cycles);
      repeat (cycles) drive(1'b0, 1'b0, rnd_word(), rnd_word(), rnd_word(), rnd_word());
   endtask

   // mode 0: splatted index+16*frame, B = index+8; mode 1: distinct lanes, imag=-real;
   // mode 2: alternating a0,a1 / b0,b1.
   task automatic run_samples(input int nsamp, input bit with_start, input int stall_at,
                              input int mode);
      int f, i, av, bv;
      for (int s = 0; s < nsamp; s++) begin
         f = s / 8;
         i = s % 8;
         if (s == stall_at) idle(3);
         case (mode)
            1: drive(with_start && s == 0, 1'b1,
                     per_lane(i + 16 * f, 1'b0), per_lane(i + 16 * f, 1'b1),
                     per_lane(i + 8 + 16 * f + 50, 1'b0), per_lane(i + 8 + 16 * f + 50, 1'b1));
            2: begin
               av = (s % 2) + 16 * f;
               bv = (s % 2) + 8 + 16 * f;
               drive(with_start && s == 0, 1'b1, splat(av), splat(av), splat(bv), splat(bv));
            end
            default: begin
               av = i + 16 * f;
               bv = i + 8 + 16 * f;
               drive(with_start && s == 0, 1'b1, splat(av), splat(av), splat(bv), splat(bv));
            end
         endcase
      end
   endtask

   // Reset lands between edges; outputs must clear before any further clock edge.
   task automatic pulse_reset();
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_eq("rst_flags_d4", 72'({out_valid_4, out_start_4}), 72'(0));
      check_eq("rst_oa_d4", {oar_4, oai_4}, 72'(0));
      check_eq("rst_ob_d4", {obr_4, obi_4}, 72'(0));
      check_eq("rst_flags_d1", 72'({out_valid_1, out_start_1}), 72'(0));
      check_eq("rst_oa_d1", {oar_1, oai_1}, 72'(0));
      check_eq("rst_ob_d1", {obr_1, obi_1}, 72'(0));
      @(negedge clk);
      rst      = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst      = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      iar = '0; iai = '0; ibr = '0; ibi = '0;
      pulse_reset();
      chk_en = 1'b1;
      idle(2);

      run_samples(32, 1'b1, -1, 0);          // fill and ordering
      run_samples(32, 1'b1, 18, 0);          // stall mid-group
      run_samples(21, 1'b1, -1, 0);          // leaves k=5 next
      run_samples(32, 1'b1, -1, 0);          // START at k=5
      pulse_reset();                          // async reset while streaming
      run_samples(32, 1'b1, -1, 0);
      run_samples(13, 1'b1, -1, 0);
      pulse_reset();
      run_samples(24, 1'b0, -1, 0);          // post-reset stream without START
      run_samples(32, 1'b1, 11, 1);          // lane independence
      run_samples(16, 1'b1, -1, 2);          // DEPTH=1 alternating pattern
      idle(1);
      drive(1'b1, 1'b0, '0, '0, '0, '0);      // START with no accept
      run_samples(24, 1'b0, -1, 0);

      for (int c = 0; c < 400; c++) begin
         drive(($urandom_range(0, 40) == 0) ? 1'b1 : 1'b0,
               ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
               rnd_word(), rnd_word(), rnd_word(), rnd_word());
      end

      idle(3);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
